// File: rtl/ahb_ic_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_ic_pkg
//  Description : Shared encodings for the AHB-Lite interconnect: HTRANS and
//                HRESP codes, controller state codes and a ceil(log2) helper
//                used to size the stall watchdog counter.
//  Revision    : 1.0  initial release
// ============================================================================
package ahb_ic_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_DATA = 2'd1;
   localparam logic [1:0] S_ERR1 = 2'd2;
   localparam logic [1:0] S_ERR2 = 2'd3;

   // Smallest r with 2**r >= value.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_ic_addr_dec.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_ic_addr_dec
//  Description : Combinational base/mask address decoder with lowest-index
//                priority. Slaves whose avail bit is low never match.
//  Ports       : addr   - decoded address bits [31:0]
//                avail  - per-slave enable (not quarantined)
//                hit    - some slave matched
//                idx    - index of the winning slave
//                onehot - one-hot select of the winner (zero on miss)
//  Revision    : 1.0  initial release
// ============================================================================
module ahb_ic_addr_dec
   import ahb_ic_pkg::*;
#(
   parameter int              NSLV = 8,
   parameter logic [NSLV*32-1:0] BASE = '0,
   parameter logic [NSLV*32-1:0] MASK = '0
) (
   input  logic [31:0]     addr,
   input  logic [NSLV-1:0] avail,
   output logic            hit,
   output logic [3:0]      idx,
   output logic [NSLV-1:0] onehot
);

   logic [NSLV-1:0] w_match;

   for (genvar i = 0; i < NSLV; i++) begin : g_cmp
      assign w_match[i] = avail[i] && ((addr & MASK[32*i +: 32]) == BASE[32*i +: 32]);
   end

   // Isolating the lowest set bit gives the priority winner directly.
   assign onehot = w_match & ~(w_match - NSLV'(1));
   assign hit    = |w_match;

   always_comb begin
      idx = 4'd0;
      for (int i = NSLV - 1; i >= 0; i--) begin
         if (w_match[i]) idx = 4'(i);
      end
   end

endmodule
`default_nettype wire

// File: rtl/ahb_interconnect_n.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_interconnect_n
//  Description : Single-master AHB-Lite interconnect: programmable decoder,
//                response mux, default slave (two-cycle ERROR for unmapped
//                accesses) and per-transfer stall watchdog with quarantine.
//  Ports       : clk, rst              - clock, async active-high reset
//                HADDR, HTRANS         - master address phase
//                HSEL                  - per-slave select (combinational)
//                HREADY, HRESP, HRDATA - response to master / HREADYIN
//                HREADYOUT_S, HRESP_S, HRDATA_S - slave responses
//                tout_flag, tout_slv, tout_clr  - watchdog status/clear
//  Revision    : 1.0  initial release
// ============================================================================
module ahb_interconnect_n
   import ahb_ic_pkg::*;
#(
   parameter int                 NSLV     = 8,
   parameter int                 DW       = 64,
   parameter logic [NSLV*32-1:0] BASE     = '0,
   parameter logic [NSLV*32-1:0] MASK     = '0,
   parameter int                 TOUT_CYC = 1024
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [63:0]        HADDR,
   input  logic [1:0]         HTRANS,
   output logic [NSLV-1:0]    HSEL,
   output logic               HREADY,
   output logic               HRESP,
   output logic [DW-1:0]      HRDATA,
   input  logic [NSLV-1:0]    HREADYOUT_S,
   input  logic [NSLV-1:0]    HRESP_S,
   input  logic [NSLV*DW-1:0] HRDATA_S,
   output logic               tout_flag,
   output logic [3:0]         tout_slv,
   input  logic               tout_clr
);

   localparam int CW_RAW = clog2(TOUT_CYC + 1);
   localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;
   // Abort fires on the stall cycle whose increment would reach TOUT_CYC,
   // so ERR1 appears in data-phase cycle TOUT_CYC+1.
   localparam int LIMIT  = (TOUT_CYC > 0) ? TOUT_CYC - 1 : 0;

   logic [1:0]      r_state;
   logic [1:0]      w_state_nxt;
   logic [3:0]      r_dsel;
   logic [CW-1:0]   r_cnt;
   logic [NSLV-1:0] r_quar;
   logic            r_tout_flag;
   logic [3:0]      r_tout_slv;

   logic            w_hit;
   logic [3:0]      w_idx;
   logic [NSLV-1:0] w_onehot;
   logic            w_xfer;
   logic            w_load;
   logic            w_abort;
   logic            w_slv_rdy;
   logic            w_slv_resp;
   logic [DW-1:0]   w_slv_rdata;
   logic [NSLV-1:0] w_q_set;
   logic [NSLV-1:0] w_q_clr;
   logic            w_unused_haddr;

   // Slave responses padded to 16 entries so the 4-bit dsel indexes safely.
   logic [15:0]     w_rdy_pad;
   logic [15:0]     w_resp_pad;
   logic [DW-1:0]   w_rdata_arr [16];

   assign w_unused_haddr = ^HADDR[63:32];

   ahb_ic_addr_dec #(
      .NSLV (NSLV),
      .BASE (BASE),
      .MASK (MASK)
   ) u_dec (
      .addr   (HADDR[31:0]),
      .avail  (~r_quar),
      .hit    (w_hit),
      .idx    (w_idx),
      .onehot (w_onehot)
   );

   assign HSEL = rst ? '0 : w_onehot;

   for (genvar k = 0; k < 16; k++) begin : g_pad
      if (k < NSLV) begin : g_real
         assign w_rdy_pad[k]   = HREADYOUT_S[k];
         assign w_resp_pad[k]  = HRESP_S[k];
         assign w_rdata_arr[k] = HRDATA_S[DW*k +: DW];
      end else begin : g_zero
         assign w_rdy_pad[k]   = 1'b1;
         assign w_resp_pad[k]  = 1'b0;
         assign w_rdata_arr[k] = '0;
      end
   end

   assign w_slv_rdy   = w_rdy_pad[r_dsel];
   assign w_slv_resp  = w_resp_pad[r_dsel];
   assign w_slv_rdata = w_rdata_arr[r_dsel];

   assign w_xfer  = (HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ);
   assign w_load  = HREADY && w_xfer && w_hit;
   assign w_abort = (TOUT_CYC != 0) && (r_state == S_DATA) && !w_slv_rdy &&
                    (r_cnt == CW'(LIMIT));

   // Response mux
   always_comb begin
      HREADY = 1'b1;
      HRESP  = HRESP_OKAY;
      HRDATA = '0;
      case (r_state)
         S_DATA: begin
            HREADY = w_slv_rdy;
            HRESP  = w_slv_resp;
            HRDATA = w_slv_rdata;
         end
         S_ERR1: begin
            HREADY = 1'b0;
            HRESP  = HRESP_ERROR;
         end
         S_ERR2: begin
            HRESP  = HRESP_ERROR;
         end
         default: ;
      endcase
   end

   // Next state: ERR1 always proceeds to ERR2; everything else follows the
   // address-phase rule whenever HREADY is high, or aborts on watchdog expiry.
   always_comb begin
      w_state_nxt = r_state;
      if (r_state == S_ERR1) begin
         w_state_nxt = S_ERR2;
      end else if (w_abort) begin
         w_state_nxt = S_ERR1;
      end else if (HREADY) begin
         if (w_xfer) w_state_nxt = w_hit ? S_DATA : S_ERR1;
         else        w_state_nxt = S_IDLE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_dsel  <= 4'd0;
      end else begin
         r_state <= w_state_nxt;
         if (w_load) r_dsel <= w_idx;
      end
   end

   // Saturating stall counter, restarted by every new data phase.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (w_load) begin
         r_cnt <= '0;
      end else if ((r_state == S_DATA) && !w_slv_rdy && (r_cnt != '1)) begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

   for (genvar i = 0; i < NSLV; i++) begin : g_quar
      assign w_q_set[i] = w_abort && (r_dsel == 4'(i));
      assign w_q_clr[i] = HREADYOUT_S[i] && !((r_state == S_DATA) && (r_dsel == 4'(i)));
   end

   // Setting wins over clearing; the aborted slave is low in the abort cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_quar <= '0;
      else     r_quar <= (r_quar & ~w_q_clr) | w_q_set;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tout_flag <= 1'b0;
         r_tout_slv  <= 4'd0;
      end else if (w_abort) begin
         r_tout_flag <= 1'b1;
         r_tout_slv  <= r_dsel;
      end else if (tout_clr) begin
         r_tout_flag <= 1'b0;
      end
   end

   assign tout_flag = r_tout_flag;
   assign tout_slv  = r_tout_slv;

endmodule
`default_nettype wire

// File: tb/tb_ahb_interconnect_n.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ahb_interconnect_n
//  Description : Directed self-checking bench for ahb_interconnect_n with a
//                four-slave map and an 8-cycle stall limit. Expected data-phase
//                responses are queued when the address phase is driven and
//                compared when the transfer completes.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ahb_interconnect_n;

   localparam int NSLV = 4;
   localparam int DW   = 64;
   localparam logic [127:0] BASE = {32'h4000_0000, 32'h4000_0000, 32'h2000_0000, 32'h0000_0000};
   localparam logic [127:0] MASK = {32'hF000_0000, 32'hFFFF_0000, 32'hF000_0000, 32'hF000_0000};

   localparam logic [1:0] T_IDLE   = 2'b00;
   localparam logic [1:0] T_NONSEQ = 2'b10;
   localparam logic [1:0] T_SEQ    = 2'b11;

   logic               clk;
   logic               rst;
   logic [63:0]        haddr;
   logic [1:0]         htrans;
   logic [NSLV-1:0]    hsel;
   logic               hready;
   logic               hresp;
   logic [DW-1:0]      hrdata;
   logic [NSLV-1:0]    hreadyout_s;
   logic [NSLV-1:0]    hresp_s;
   logic [NSLV*DW-1:0] hrdata_s;
   logic               tout_flag;
   logic [3:0]         tout_slv;
   logic               tout_clr;

   typedef struct packed {
      logic        resp;
      logic [63:0] data;
   } exp_t;

   exp_t sb[$];
   int   n_pass;
   int   n_total;

   ahb_interconnect_n #(
      .NSLV     (NSLV),
      .DW       (DW),
      .BASE     (BASE),
      .MASK     (MASK),
      .TOUT_CYC (8)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .HADDR       (haddr),
      .HTRANS      (htrans),
      .HSEL        (hsel),
      .HREADY      (hready),
      .HRESP       (hresp),
      .HRDATA      (hrdata),
      .HREADYOUT_S (hreadyout_s),
      .HRESP_S     (hresp_s),
      .HRDATA_S    (hrdata_s),
      .tout_flag   (tout_flag),
      .tout_slv    (tout_slv),
      .tout_clr    (tout_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic set_data(input int i, input logic [63:0] d);
      hrdata_s[i*64 +: 64] = d;
   endtask

   // Drive one address phase and check the cycle. When the bench expects
   // HREADY high, the pending data phase completes (pop) and the driven
   // address phase is accepted (push its expected response).
   task automatic step(input logic [63:0] a, input logic [1:0] t, input logic [3:0] exp_hsel,
                       input logic exp_rdy, input logic nxt_resp, input logic [63:0] nxt_data);
      exp_t e;
      haddr  = a;
      htrans = t;
      #2;
      chk("hsel", 64'(hsel), 64'(exp_hsel));
      chk("hready", 64'(hready), 64'(exp_rdy));
      if (exp_rdy) begin
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("hresp", 64'(hresp), 64'(e.resp));
            chk("hrdata", hrdata, e.data);
         end
         e.resp = nxt_resp;
         e.data = nxt_data;
         sb.push_back(e);
      end
   endtask

   // Master holds an IDLE to slave0 while the current data phase stalls.
   task automatic stall(input int n);
      for (int k = 0; k < n; k++) begin
         step(64'h0, T_IDLE, 4'b0001, 1'b0, 1'b0, 64'h0);
         tick();
      end
   endtask

   initial begin
      n_pass      = 0;
      n_total     = 0;
      rst         = 1'b1;
      tout_clr    = 1'b0;
      haddr       = 64'h2000_0000;
      htrans      = T_NONSEQ;
      hreadyout_s = 4'b1111;
      hresp_s     = 4'b0000;
      hrdata_s    = '0;
      set_data(0, 64'h1111);
      set_data(1, 64'hDEAD_BEEF);
      set_data(2, 64'h2222);
      set_data(3, 64'h3333);

      // Reset state
      tick();
      tick();
      chk("rst_hsel", 64'(hsel), 64'h0);
      chk("rst_hready", 64'(hready), 64'h1);
      chk("rst_hresp", 64'(hresp), 64'h0);
      chk("rst_hrdata", hrdata, 64'h0);
      chk("rst_tout_flag", 64'(tout_flag), 64'h0);
      chk("rst_tout_slv", 64'(tout_slv), 64'h0);
      rst = 1'b0;

      // Routing and priority
      step(64'h2000_0008, T_NONSEQ, 4'b0010, 1'b1, 1'b0, 64'hDEAD_BEEF); tick();
      step(64'h4000_0010, T_NONSEQ, 4'b0100, 1'b1, 1'b0, 64'h2222);      tick();
      step(64'h4800_0000, T_NONSEQ, 4'b1000, 1'b1, 1'b0, 64'h3333);      tick();

      // Unmapped access: ERR1 then ERR2, then an IDLE with zero wait
      step(64'h8000_0000, T_NONSEQ, 4'b0000, 1'b1, 1'b1, 64'h0);         tick();
      step(64'h8000_0000, T_IDLE,   4'b0000, 1'b0, 1'b0, 64'h0);
      chk("err1_hresp", 64'(hresp), 64'h1);
      chk("err1_hrdata", hrdata, 64'h0);
      tick();
      step(64'h8000_0000, T_IDLE,   4'b0000, 1'b1, 1'b0, 64'h0);         tick();

      // Zero-wait burst to slave0
      step(64'h00, T_NONSEQ, 4'b0001, 1'b1, 1'b0, 64'hA0); tick();
      set_data(0, 64'hA0);
      step(64'h08, T_SEQ,    4'b0001, 1'b1, 1'b0, 64'hA1); tick();
      set_data(0, 64'hA1);
      step(64'h10, T_SEQ,    4'b0001, 1'b1, 1'b0, 64'hA2); tick();
      set_data(0, 64'hA2);
      step(64'h18, T_SEQ,    4'b0001, 1'b1, 1'b0, 64'hA3); tick();
      set_data(0, 64'hA3);
      step(64'h00, T_IDLE,   4'b0001, 1'b1, 1'b0, 64'h0);  tick();

      // Slave1 stalls: abort, flag, quarantine, release
      hreadyout_s[1] = 1'b0;
      step(64'h2000_0000, T_NONSEQ, 4'b0010, 1'b1, 1'b1, 64'h0); tick();
      stall(7);
      step(64'h0, T_IDLE, 4'b0001, 1'b0, 1'b0, 64'h0);
      chk("stall8_tout_flag", 64'(tout_flag), 64'h0);
      tick();
      step(64'h0, T_IDLE, 4'b0001, 1'b0, 1'b0, 64'h0);
      chk("abort1_hresp", 64'(hresp), 64'h1);
      chk("abort1_flag", 64'(tout_flag), 64'h1);
      chk("abort1_slv", 64'(tout_slv), 64'h1);
      tick();
      step(64'h2000_0000, T_NONSEQ, 4'b0000, 1'b1, 1'b1, 64'h0); tick();
      step(64'h2000_0000, T_IDLE,   4'b0000, 1'b0, 1'b0, 64'h0);
      chk("quar_err1_hresp", 64'(hresp), 64'h1);
      tick();
      hreadyout_s[1] = 1'b1;
      step(64'h2000_0000, T_IDLE,   4'b0000, 1'b1, 1'b0, 64'h0); tick();
      step(64'h2000_0010, T_NONSEQ, 4'b0010, 1'b1, 1'b0, 64'hDEAD_BEEF); tick();
      tout_clr = 1'b1;
      step(64'h0, T_IDLE, 4'b0001, 1'b1, 1'b0, 64'h0); tick();
      tout_clr = 1'b0;

      // Second abort on slave2 with a coincident clear
      hreadyout_s[2] = 1'b0;
      step(64'h4000_0000, T_NONSEQ, 4'b0100, 1'b1, 1'b1, 64'h0);
      chk("clr_flag", 64'(tout_flag), 64'h0);
      tick();
      stall(7);
      tout_clr = 1'b1;
      step(64'h0, T_IDLE, 4'b0001, 1'b0, 1'b0, 64'h0); tick();
      tout_clr = 1'b0;
      step(64'h0, T_IDLE, 4'b0001, 1'b0, 1'b0, 64'h0);
      chk("abort2_flag", 64'(tout_flag), 64'h1);
      chk("abort2_slv", 64'(tout_slv), 64'h2);
      tick();
      // Slave2 quarantined: 0x4000_0000 falls through to slave3
      step(64'h4000_0000, T_NONSEQ, 4'b1000, 1'b1, 1'b0, 64'h3333); tick();
      hreadyout_s[2] = 1'b1;
      step(64'h0, T_IDLE, 4'b0001, 1'b1, 1'b0, 64'h0); tick();

      // Reset during ERR1 of an abort
      hreadyout_s[1] = 1'b0;
      step(64'h2000_0000, T_NONSEQ, 4'b0010, 1'b1, 1'b0, 64'h0); tick();
      stall(8);
      step(64'h0, T_IDLE, 4'b0001, 1'b0, 1'b0, 64'h0);
      chk("abort3_hresp", 64'(hresp), 64'h1);
      rst = 1'b1;
      #1;
      chk("mrst_hready", 64'(hready), 64'h1);
      chk("mrst_hresp", 64'(hresp), 64'h0);
      chk("mrst_hsel", 64'(hsel), 64'h0);
      chk("mrst_flag", 64'(tout_flag), 64'h0);
      sb.delete();
      tick();
      rst = 1'b0;
      // Slave1 still low, so only reset could have lifted its quarantine
      step(64'h2000_0000, T_NONSEQ, 4'b0010, 1'b1, 1'b0, 64'hDEAD_BEEF); tick();
      hreadyout_s[1] = 1'b1;
      step(64'h0, T_IDLE, 4'b0001, 1'b1, 1'b0, 64'h0); tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
